// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration path: bitstream control
// words, controller state encoding and the frame header layout.
package fabric_cfg_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_STROBE,
    ST_ERR
  } cfg_state_e;

  // Header word layout: column in [31:24], frame in [23:16], word count in [15:0].
  typedef struct packed {
    logic [7:0]  column;
    logic [7:0]  frame;
    logic [15:0] count;
  } frame_hdr_t;

endpackage

// File: rtl/frame_strobe_decode.sv
// Turns a (column, frame) address into the one-hot frame write strobe.
module frame_strobe_decode #(
  parameter int NUM_COLUMNS = 4,
  parameter int MAX_FRAMES  = 20
) (
  input  logic [7:0]                          column,
  input  logic [7:0]                          frame,
  input  logic                                enable,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0]   strobe
);

  localparam int NUM_STROBES = NUM_COLUMNS * MAX_FRAMES;

  // Index is formed at 32 bits so the largest 8-bit column/frame pair cannot overflow.
  logic [31:0] strobe_idx;
  assign strobe_idx = 32'(column) * 32'(MAX_FRAMES) + 32'(frame);

  // One-hot decode of the strobe index, all-zero when disabled.
  always_comb begin
    strobe = '0;
    for (int i = 0; i < NUM_STROBES; i++) begin
      strobe[i] = enable && (strobe_idx == 32'(i));
    end
  end

endmodule

// File: rtl/frame_config_ctrl.sv
// Bitstream-driven frame configuration controller: waits for SYNC, parses
// frame headers, collects one word per tile row and fires a single frame strobe.
module frame_config_ctrl
  import fabric_cfg_pkg::*;
#(
  parameter int NUM_ROWS    = 4,
  parameter int NUM_COLUMNS = 4,
  parameter int MAX_FRAMES  = 20
) (
  input  logic                                CLK,
  input  logic                                resetn,
  input  logic [31:0]                         s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [NUM_ROWS*32-1:0]              FrameData_O,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0]   FrameStrobe_O,
  output logic                                cfg_active,
  output logic                                cfg_done,
  output logic                                cfg_err
);

  localparam int ROW_W = $clog2(NUM_ROWS + 1);

  cfg_state_e               state_q, state_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [7:0]               column_q, column_d;
  logic [7:0]               frame_q, frame_d;
  logic [NUM_ROWS*32-1:0]   frame_data_q, frame_data_d;
  logic                     s_ready_q, s_ready_d;
  logic                     done_q, done_d;

  frame_hdr_t hdr;
  logic       hdr_ok;
  logic       fire;
  logic       strobe_en;

  assign hdr    = frame_hdr_t'(s_data);
  assign hdr_ok = ({24'd0, hdr.column} < 32'(NUM_COLUMNS)) &&
                  ({24'd0, hdr.frame}  < 32'(MAX_FRAMES))  &&
                  (hdr.count == 16'(NUM_ROWS));
  assign fire   = s_valid && s_ready_q;

  // Next-state, header/data capture and done pulse.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state_q;
    row_d        = row_q;
    column_d     = column_q;
    frame_d      = frame_q;
    frame_data_d = frame_data_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire && s_data == SYNC_WORD) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (fire) begin
          if (s_data == DESYNC_WORD) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (hdr_ok) begin
            column_d = hdr.column;
            frame_d  = hdr.frame;
            row_d    = '0;
            state_d  = ST_DATA;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DATA: begin
        if (fire) begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_q == ROW_W'(r)) frame_data_d[32*r +: 32] = s_data;
          end
          if (row_q == ROW_W'(NUM_ROWS - 1)) state_d = ST_STROBE;
          else                               row_d   = row_q + 1'b1;
        end
      end
      ST_STROBE: state_d = ST_HDR;
      ST_ERR: begin
        if (fire) begin
          if (s_data == SYNC_WORD)        state_d = ST_HDR;
          else if (s_data == DESYNC_WORD) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    s_ready_d = (state_d != ST_STROBE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!resetn) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      column_q     <= '0;
      frame_q      <= '0;
      // NOTE: the frame data bank is reset because it drives the fabric directly and must read zero in reset.
      frame_data_q <= '0;
      s_ready_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      column_q     <= column_d;
      frame_q      <= frame_d;
      frame_data_q <= frame_data_d;
      s_ready_q    <= s_ready_d;
      done_q       <= done_d;
    end
  end

  // Strobe is gated by resetn so a reset arriving in the strobe cycle kills it at once.
  assign strobe_en = (state_q == ST_STROBE) && resetn;

  frame_strobe_decode #(
    .NUM_COLUMNS (NUM_COLUMNS),
    .MAX_FRAMES  (MAX_FRAMES)
  ) u_strobe_decode (
    .column (column_q),
    .frame  (frame_q),
    .enable (strobe_en),
    .strobe (FrameStrobe_O)
  );

  assign s_ready     = s_ready_q;
  assign FrameData_O = frame_data_q;
  assign cfg_active  = (state_q != ST_IDLE);
  assign cfg_err     = (state_q == ST_ERR);
  assign cfg_done    = done_q;

endmodule

// File: doc/frame_config_ctrl.md
FRAME_CONFIG_CTRL -- requirements
Module: frame_config_ctrl

Interface
REQ-001 Parameter NUM_ROWS, default 4, sets the number of tile rows; each row takes 32 frame bits.
REQ-002 Parameter NUM_COLUMNS, default 4, sets the number of tile columns.
REQ-003 Parameter MAX_FRAMES, default 20, sets the number of frame strobes per column.
REQ-004 Port CLK, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-005 Port resetn, input, 1 bit: reset; synchronous, active-low.
REQ-006 Port s_data, input, 32 bits: bitstream word.
REQ-007 Port s_valid, input, 1 bit: s_data is valid.
REQ-008 Port s_ready, output, 1 bit: the block accepts a word; a transfer happens when s_valid and s_ready are both high.
REQ-009 Port FrameData_O, output, NUM_ROWS*32 bits: frame data to the fabric; row r occupies bits [32r+31:32r].
REQ-010 Port FrameStrobe_O, output, NUM_COLUMNS*MAX_FRAMES bits: one-hot write strobe; index = column*MAX_FRAMES + frame.
REQ-011 Port cfg_active, output, 1 bit: high between SYNC and DESYNC.
REQ-012 Port cfg_done, output, 1 bit: one-cycle pulse on DESYNC.
REQ-013 Port cfg_err, output, 1 bit: sticky error flag.

Function
REQ-014 The FSM SHALL have the states IDLE, HDR, DATA, STROBE and ERR.
REQ-015 IDLE: any accepted word other than SYNC (32'hFAB0_FAB1) SHALL be discarded; SYNC SHALL move to HDR and clear cfg_err.
REQ-016 HDR: an accepted DESYNC (32'hFAB0_FAB0) SHALL pulse cfg_done for one cycle and move to IDLE.
REQ-017 HDR: any other accepted word is a header with column=[31:24], frame=[23:16], count=[15:0].
REQ-018 A valid header (column<NUM_COLUMNS, frame<MAX_FRAMES, count==NUM_ROWS) SHALL latch column and frame, clear the row index, and move to DATA; any other header SHALL move to ERR.
REQ-019 DATA: accepted word k SHALL be written to FrameData_O row k, starting at row 0; after row NUM_ROWS-1 is accepted, the FSM SHALL move to STROBE.
REQ-020 STROBE: exactly one bit of FrameStrobe_O SHALL be high, for exactly one cycle, in the cycle after the last data word is accepted; s_ready SHALL be low; the next state is HDR.
REQ-021 FrameStrobe_O SHALL be all-zero in every state except STROBE.
REQ-022 FrameData_O SHALL hold its value from the last data write through the strobe cycle and until the next DATA write.
REQ-023 s_ready SHALL be high in IDLE, HDR, DATA and ERR, and low in STROBE.
REQ-024 ERR: cfg_err SHALL be high; accepted words SHALL be discarded until SYNC, which SHALL move to HDR and clear cfg_err; DESYNC in ERR SHALL move to IDLE without a cfg_done pulse.
REQ-025 A SYNC word received in DATA SHALL be stored as data, not treated as a sync.
REQ-026 s_valid low SHALL stall the FSM in its current state with no change.
REQ-027 cfg_active SHALL be high in HDR, DATA, STROBE and ERR, and low in IDLE.
REQ-028 The row index SHALL be ceil(log2(NUM_ROWS+1)) bits wide and SHALL never wrap past NUM_ROWS-1.
REQ-029 The strobe index SHALL be computed as column*MAX_FRAMES+frame at full width, with no truncation.

Reset
REQ-030 While resetn is low at a clock edge, the block SHALL enter IDLE and force the following values, including mid-frame: FrameData_O=0, FrameStrobe_O=0, cfg_active=0, cfg_done=0, cfg_err=0, s_ready=0.
REQ-031 s_ready SHALL rise on the first edge after resetn goes high.
REQ-032 A reset during STROBE SHALL suppress the strobe in that same cycle.

Structure
REQ-033 The SYNC/DESYNC constants, the state enum and the header field positions SHALL live in the shared package fabric_cfg_pkg.
REQ-034 One sub-module, frame_strobe_decode (column, frame, enable -> one-hot strobe), SHALL be instantiated; all other logic SHALL be inline.

Verification
REQ-035 SYNC, header 0x0102_0004, data 0x11,0x22,0x33,0x44, DESYNC -> FrameData_O={0x44,0x33,0x22,0x11}; FrameStrobe_O[22] high for 1 cycle, 1 cycle after the 0x44 handshake; cfg_done pulses once.
REQ-036 SYNC, header 0x0400_0004 (column out of range) -> cfg_err=1 and no strobe; the next SYNC clears cfg_err and a valid header 0x0000_0004 works.
REQ-037 Header count 3 -> ERR, no strobe, and the following data words are ignored.
REQ-038 Random s_valid gaps during DATA -> strobe content and timing identical to the gap-free case; s_ready=0 only in the STROBE cycle.
REQ-039 resetn low after 2 of 4 data words, then the full frame resent after SYNC -> no strobe before reset; a correct strobe after; all outputs zero during reset.
REQ-040 Two back-to-back frames (column 3, frame 19; column 0, frame 0) -> strobes on bit 79 then bit 0, separated by the header and data cycles, with never two strobe bits high at once.
